// File: rtl/ml_acc_pkg.sv
// Shared types and constants for the ml_acc_system dot-product sequencer.
package ml_acc_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StIssue,
    StDrain,
    StDone
  } state_e;

  localparam int unsigned START_REG = 10;

  localparam logic [31:0] INPUT_BRAM_BASE  = 32'h4000_0000;
  localparam logic [31:0] WEIGHT_BRAM_BASE = 32'h4200_0000;
  localparam logic [31:0] CTRL_BASE        = 32'h43C0_0000;

  localparam int unsigned DefAddrW = 10;
  localparam int unsigned DefDataW = 32;
  localparam int unsigned DefAccW  = 64;
  localparam int unsigned DefRdLat = 1;

endpackage

// File: rtl/ml_acc_mac.sv
// Two-stage signed multiply-accumulate: stage 1 registers the product, stage 2 accumulates.
module ml_acc_mac
  import ml_acc_pkg::*;
#(
  parameter int unsigned DATA_W = DefDataW,
  parameter int unsigned ACC_W  = DefAccW
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              clr_i,
  input  logic              flush_i,
  input  logic              in_valid_i,
  input  logic [DATA_W-1:0] a_i,
  input  logic [DATA_W-1:0] b_i,
  output logic [ACC_W-1:0]  acc_o,
  output logic              busy_o
);

  logic signed [2*DATA_W-1:0] prod;
  logic signed [2*DATA_W-1:0] prod_q;
  logic                       p_vld_q;
  logic        [ACC_W-1:0]    prod_ext;
  logic        [ACC_W-1:0]    acc_q;

  // Operands are widened first so the product is exact at 2*DATA_W bits.
  assign prod = $signed({{DATA_W{a_i[DATA_W-1]}}, a_i}) *
                $signed({{DATA_W{b_i[DATA_W-1]}}, b_i});
  assign prod_ext = ACC_W'(prod_q);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      prod_q  <= '0;
      p_vld_q <= 1'b0;
    end else begin
      p_vld_q <= (clr_i || flush_i) ? 1'b0 : in_valid_i;
      if (in_valid_i) begin
        prod_q <= prod;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      acc_q <= '0;
    end else if (clr_i) begin
      acc_q <= '0;
    end else if (p_vld_q) begin
      acc_q <= acc_q + prod_ext;
    end
  end

  assign acc_o  = acc_q;
  assign busy_o = p_vld_q;

endmodule

// File: rtl/ml_acc_seq.sv
// Dot-product sequencer: streams len words from the Input/Weight BRAMs into the MAC
// and reports the signed sum with a done pulse and sticky valid flag.
module ml_acc_seq
  import ml_acc_pkg::*;
#(
  parameter int unsigned ADDR_W = DefAddrW,
  parameter int unsigned DATA_W = DefDataW,
  parameter int unsigned ACC_W  = DefAccW,
  parameter int unsigned RD_LAT = DefRdLat
) (
  input  logic              ACLK,
  input  logic              ARESETn,
  input  logic              start_i,
  input  logic              abort_i,
  input  logic [ADDR_W:0]   len_i,
  input  logic [ADDR_W-1:0] x_base_i,
  input  logic [ADDR_W-1:0] w_base_i,
  output logic              x_en_o,
  output logic              w_en_o,
  output logic [ADDR_W-1:0] x_addr_o,
  output logic [ADDR_W-1:0] w_addr_o,
  input  logic [DATA_W-1:0] x_rdata_i,
  input  logic [DATA_W-1:0] w_rdata_i,
  output logic [ACC_W-1:0]  result_o,
  output logic              result_valid_o,
  output logic              busy_o,
  output logic              done_o,
  output logic              start_err_o
);

  state_e              state_q, state_d;
  logic [ADDR_W:0]     idx_q, idx_d;
  logic [ADDR_W:0]     len_q, len_d;
  logic [ADDR_W-1:0]   xb_q, xb_d;
  logic [ADDR_W-1:0]   wb_q, wb_d;
  logic                rv_q, rv_d;
  logic                err_q, err_d;
  logic [RD_LAT-1:0]   vpipe_q, vpipe_d;
  logic                issue;
  logic                accept;
  logic                mac_busy;

  assign issue  = (state_q == StIssue);
  assign accept = (state_q == StIdle) && start_i && !abort_i;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    len_d   = len_q;
    xb_d    = xb_q;
    wb_d    = wb_q;
    rv_d    = rv_q;
    err_d   = err_q;
    if (abort_i) begin
      state_d = StIdle;
      rv_d    = 1'b0;
    end else begin
      if (start_i && (state_q != StIdle)) begin
        err_d = 1'b1;
      end
      unique case (state_q)
        StIdle: begin
          if (start_i) begin
            len_d = len_i;
            xb_d  = x_base_i;
            wb_d  = w_base_i;
            idx_d = '0;
            err_d = 1'b0;
            // Zero-length jobs skip straight to completion with a cleared sum.
            rv_d    = (len_i == '0);
            state_d = (len_i == '0) ? StDone : StIssue;
          end
        end
        StIssue: begin
          idx_d = idx_q + 1'b1;
          if (idx_q == len_q - 1'b1) begin
            state_d = StDrain;
          end
        end
        StDrain: begin
          if ((vpipe_q == '0) && !mac_busy) begin
            state_d = StDone;
            rv_d    = 1'b1;
          end
        end
        StDone: begin
          state_d = StIdle;
        end
        default: state_d = StIdle;
      endcase
    end
  end

  // Tags which cycles carry returning BRAM data; the last stage feeds the MAC.
  always_comb begin
    vpipe_d = '0;
    if (!abort_i) begin
      vpipe_d[0] = issue;
      for (int i = 1; i < RD_LAT; i++) begin
        vpipe_d[i] = vpipe_q[i-1];
      end
    end
  end

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      state_q <= StIdle;
      idx_q   <= '0;
      len_q   <= '0;
      xb_q    <= '0;
      wb_q    <= '0;
      rv_q    <= 1'b0;
      err_q   <= 1'b0;
      vpipe_q <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      len_q   <= len_d;
      xb_q    <= xb_d;
      wb_q    <= wb_d;
      rv_q    <= rv_d;
      err_q   <= err_d;
      vpipe_q <= vpipe_d;
    end
  end

  ml_acc_mac #(
    .DATA_W(DATA_W),
    .ACC_W (ACC_W)
  ) u_mac (
    .clk_i     (ACLK),
    .rst_ni    (ARESETn),
    .clr_i     (accept),
    .flush_i   (abort_i),
    .in_valid_i(vpipe_q[RD_LAT-1]),
    .a_i       (x_rdata_i),
    .b_i       (w_rdata_i),
    .acc_o     (result_o),
    .busy_o    (mac_busy)
  );

  assign x_en_o         = issue;
  assign w_en_o         = issue;
  assign x_addr_o       = xb_q + idx_q[ADDR_W-1:0];
  assign w_addr_o       = wb_q + idx_q[ADDR_W-1:0];
  assign result_valid_o = rv_q;
  assign busy_o         = (state_q != StIdle);
  assign done_o         = (state_q == StDone);
  assign start_err_o    = err_q;

endmodule

// File: tb/tb_ml_acc_seq.sv
// Bench for ml_acc_seq: two instances (RD_LAT 1 and 3) checked every cycle against a
// job-timeline model, plus directed literal expectations.
module tb_ml_acc_seq;

  localparam int unsigned AW   = 10;
  localparam int unsigned DW   = 32;
  localparam int unsigned AccW = 64;

  logic ACLK = 1'b0;
  logic ARESETn;
  logic start, abort;
  logic [AW:0]   len;
  logic [AW-1:0] xb, wb;

  logic            x_en[2], w_en[2], rv[2], busy[2], done[2], serr[2];
  logic [AW-1:0]   x_addr[2], w_addr[2];
  logic [DW-1:0]   x_rd[2], w_rd[2];
  logic [AccW-1:0] result[2];

  logic [31:0] xmem[1024];
  logic [31:0] wmem[1024];
  logic [31:0] xp[2][3];
  logic [31:0] wp[2][3];

  int n_chk  = 0;
  int n_fail = 0;
  int unsigned cyc = 0;

  always #5 ACLK = ~ACLK;

  ml_acc_seq #(.ADDR_W(AW), .DATA_W(DW), .ACC_W(AccW), .RD_LAT(1)) u_dut1 (
    .ACLK(ACLK), .ARESETn(ARESETn), .start_i(start), .abort_i(abort), .len_i(len),
    .x_base_i(xb), .w_base_i(wb), .x_en_o(x_en[0]), .w_en_o(w_en[0]),
    .x_addr_o(x_addr[0]), .w_addr_o(w_addr[0]), .x_rdata_i(x_rd[0]), .w_rdata_i(w_rd[0]),
    .result_o(result[0]), .result_valid_o(rv[0]), .busy_o(busy[0]), .done_o(done[0]),
    .start_err_o(serr[0])
  );

  ml_acc_seq #(.ADDR_W(AW), .DATA_W(DW), .ACC_W(AccW), .RD_LAT(3)) u_dut3 (
    .ACLK(ACLK), .ARESETn(ARESETn), .start_i(start), .abort_i(abort), .len_i(len),
    .x_base_i(xb), .w_base_i(wb), .x_en_o(x_en[1]), .w_en_o(w_en[1]),
    .x_addr_o(x_addr[1]), .w_addr_o(w_addr[1]), .x_rdata_i(x_rd[1]), .w_rdata_i(w_rd[1]),
    .result_o(result[1]), .result_valid_o(rv[1]), .busy_o(busy[1]), .done_o(done[1]),
    .start_err_o(serr[1])
  );

  // BRAM read ports: data appears RD_LAT cycles after the enable.
  always @(posedge ACLK) begin
    for (int d = 0; d < 2; d++) begin
      xp[d][0] <= x_en[d] ? xmem[x_addr[d]] : 32'hA5A5_5A5A;
      wp[d][0] <= w_en[d] ? wmem[w_addr[d]] : 32'h5A5A_A5A5;
      xp[d][1] <= xp[d][0];
      xp[d][2] <= xp[d][1];
      wp[d][1] <= wp[d][0];
      wp[d][2] <= wp[d][1];
    end
  end
  assign x_rd[0] = xp[0][0];
  assign w_rd[0] = wp[0][0];
  assign x_rd[1] = xp[1][2];
  assign w_rd[1] = wp[1][2];

  always @(posedge ACLK) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @cyc %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  function automatic longint dot(input int unsigned n, input int unsigned xbase,
                                 input int unsigned wbase);
    longint s = 0;
    for (int i = 0; i < int'(n); i++) begin
      s += longint'($signed(xmem[(xbase + i) % 1024])) *
           longint'($signed(wmem[(wbase + i) % 1024]));
    end
    return s;
  endfunction

  // Job-timeline model: a job accepted at cycle t0 enables for len cycles, completes
  // len+lat+2 cycles later (or at t0 when len is 0).
  logic        m_act[2], m_rv[2], m_err[2], m_rk[2];
  int unsigned m_t0[2], m_done[2], m_len[2], m_xb[2], m_wb[2];
  longint      m_sum[2], m_rexp[2];

  always @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      for (int d = 0; d < 2; d++) begin
        m_act[d] = 1'b0; m_rv[d] = 1'b0; m_err[d] = 1'b0; m_rk[d] = 1'b1; m_rexp[d] = 0;
      end
    end else begin
      for (int d = 0; d < 2; d++) begin
        int unsigned c;
        logic bp;
        c  = cyc + 1;
        bp = m_act[d] && (c - 1 >= m_t0[d]) && (c - 1 <= m_done[d]);
        if (m_act[d] && (c - 1 >= m_done[d])) m_act[d] = 1'b0;
        if (abort) begin
          if (bp) m_rk[d] = 1'b0;
          m_act[d] = 1'b0;
          m_rv[d]  = 1'b0;
        end else if (start) begin
          if (bp) begin
            m_err[d] = 1'b1;
          end else begin
            m_act[d]  = 1'b1;
            m_t0[d]   = c;
            m_len[d]  = int'(len);
            m_xb[d]   = int'(xb);
            m_wb[d]   = int'(wb);
            m_sum[d]  = dot(m_len[d], m_xb[d], m_wb[d]);
            m_done[d] = (m_len[d] == 0) ? c : c + m_len[d] + ((d == 0) ? 1 : 3) + 2;
            m_err[d]  = 1'b0;
            m_rv[d]   = 1'b0;
            m_rk[d]   = 1'b0;
          end
        end
        if (m_act[d] && (c == m_done[d])) begin
          m_rv[d]   = 1'b1;
          m_rk[d]   = 1'b1;
          m_rexp[d] = m_sum[d];
        end
      end
    end
  end

  always @(negedge ACLK) begin
    for (int d = 0; d < 2; d++) begin
      if (!ARESETn) begin
        chk($sformatf("d%0d rst x_en", d), 64'(x_en[d]), 64'd0);
        chk($sformatf("d%0d rst w_en", d), 64'(w_en[d]), 64'd0);
        chk($sformatf("d%0d rst addr", d), 64'({x_addr[d], w_addr[d]}), 64'd0);
        chk($sformatf("d%0d rst result", d), result[d], 64'd0);
        chk($sformatf("d%0d rst flags", d), 64'({rv[d], busy[d], done[d], serr[d]}), 64'd0);
      end else begin
        logic e_en, e_busy, e_done;
        e_en   = m_act[d] && (cyc >= m_t0[d]) && (cyc < m_t0[d] + m_len[d]);
        e_busy = m_act[d] && (cyc >= m_t0[d]) && (cyc <= m_done[d]);
        e_done = m_act[d] && (cyc == m_done[d]);
        chk($sformatf("d%0d x_en", d), 64'(x_en[d]), 64'(e_en));
        chk($sformatf("d%0d w_en", d), 64'(w_en[d]), 64'(e_en));
        chk($sformatf("d%0d busy", d), 64'(busy[d]), 64'(e_busy));
        chk($sformatf("d%0d done", d), 64'(done[d]), 64'(e_done));
        chk($sformatf("d%0d result_valid", d), 64'(rv[d]), 64'(m_rv[d]));
        chk($sformatf("d%0d start_err", d), 64'(serr[d]), 64'(m_err[d]));
        if (e_en) begin
          chk($sformatf("d%0d x_addr", d), 64'(x_addr[d]),
              64'((m_xb[d] + cyc - m_t0[d]) % 1024));
          chk($sformatf("d%0d w_addr", d), 64'(w_addr[d]),
              64'((m_wb[d] + cyc - m_t0[d]) % 1024));
        end
        if (m_rk[d]) chk($sformatf("d%0d result", d), result[d], m_rexp[d]);
      end
    end
  end

  int            r_off[2], r_en[2];
  logic [63:0]   r_res[2];
  logic          r_err[2];
  logic [AW-1:0] xaq[$], waq[$];

  task automatic step();
    @(posedge ACLK);
    #1;
  endtask

  task automatic wait_idle();
    for (int k = 0; k < 5000; k++) begin
      if (!busy[0] && !busy[1]) return;
      step();
    end
    chk("idle_timeout", 64'(busy[0] | busy[1]), 64'd0);
  endtask

  // Starts a job, optionally injects start (kind 1), abort (2) or both (3) at cycle T+inj.
  task automatic run_job(input int unsigned l, input int unsigned xbase,
                         input int unsigned wbase, input int inj, input int kind,
                         input int budget);
    r_off = '{-1, -1};
    r_en  = '{0, 0};
    xaq.delete();
    waq.delete();
    len   = l[AW:0];
    xb    = xbase[AW-1:0];
    wb    = wbase[AW-1:0];
    start = 1'b1;
    step();
    start = 1'b0;
    for (int k = 1; k <= budget; k++) begin
      @(negedge ACLK);
      start = (k == inj) && kind[0];
      abort = (k == inj) && kind[1];
      for (int d = 0; d < 2; d++) begin
        if (r_off[d] < 0) begin
          if (x_en[d] || w_en[d]) r_en[d]++;
          if (d == 0 && x_en[0]) begin
            xaq.push_back(x_addr[0]);
            waq.push_back(w_addr[0]);
          end
          if (done[d]) begin
            r_off[d] = k;
            r_res[d] = result[d];
            r_err[d] = serr[d];
          end
        end
      end
      if (r_off[0] >= 0 && r_off[1] >= 0) break;
    end
    if (start || abort) step();
    start = 1'b0;
    abort = 1'b0;
  endtask

  function automatic logic [31:0] rval();
    case ($urandom_range(0, 7))
      0:       return 32'h7FFF_FFFF;
      1:       return 32'h8000_0000;
      2:       return 32'hFFFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  task automatic fill_random();
    for (int i = 0; i < 1024; i++) begin
      xmem[i] = rval();
      wmem[i] = rval();
    end
  endtask

  initial begin
    logic [AW-1:0] exp_a[4];
    start = 0; abort = 0; len = '0; xb = '0; wb = '0;
    fill_random();
    ARESETn = 1'b1;
    #2 ARESETn = 1'b0;
    repeat (3) @(posedge ACLK);
    #1 ARESETn = 1'b1;
    @(negedge ACLK);
    chk("reset result", result[0], 64'd0);
    chk("reset busy", 64'({busy[0], busy[1]}), 64'd0);

    // Basic sum: x_i = i, w_i = 1.
    for (int i = 0; i < 25; i++) begin xmem[i] = i; wmem[i] = 1; end
    chk("model basic", 64'(dot(25, 0, 0)), 64'd300);
    step();
    run_job(25, 0, 0, 0, 0, 100);
    chk("basic en cycles", 64'(r_en[0]), 64'd25);
    chk("basic done lat1", 64'(r_off[0]), 64'd29);
    chk("basic done lat3", 64'(r_off[1]), 64'd31);
    chk("basic result lat1", r_res[0], 64'd300);
    chk("basic result lat3", r_res[1], 64'd300);
    wait_idle();

    // Signed operands.
    for (int i = 0; i < 4; i++) begin xmem[i] = 32'd2; wmem[i] = 32'hFFFF_FFFF; end
    run_job(4, 0, 0, 0, 0, 40);
    chk("signed -8", r_res[0], 64'hFFFF_FFFF_FFFF_FFF8);
    chk("signed -8 lat3", r_res[1], 64'hFFFF_FFFF_FFFF_FFF8);
    wait_idle();
    for (int i = 0; i < 4; i++) begin xmem[i] = 32'h7FFF_FFFF; wmem[i] = 32'h7FFF_FFFF; end
    run_job(4, 0, 0, 0, 0, 40);
    chk("max product sum", r_res[0], 64'hFFFF_FFFC_0000_0004);
    wait_idle();

    // Address wrap.
    run_job(4, 'h3FE, 'h3FE, 0, 0, 40);
    exp_a = '{10'h3FE, 10'h3FF, 10'h000, 10'h001};
    chk("wrap count", 64'(xaq.size()), 64'd4);
    for (int i = 0; i < 4 && i < xaq.size(); i++) begin
      chk($sformatf("wrap x_addr %0d", i), 64'(xaq[i]), 64'(exp_a[i]));
      chk($sformatf("wrap w_addr %0d", i), 64'(waq[i]), 64'(exp_a[i]));
    end
    wait_idle();

    // Zero length.
    run_job(0, 5, 5, 0, 0, 20);
    chk("len0 done", 64'(r_off[0]), 64'd1);
    chk("len0 done lat3", 64'(r_off[1]), 64'd1);
    chk("len0 no reads", 64'(r_en[0] + r_en[1]), 64'd0);
    chk("len0 result", r_res[0], 64'd0);
    wait_idle();

    // Start while busy at idx 10.
    fill_random();
    run_job(25, 100, 200, 11, 1, 100);
    chk("busy start done", 64'(r_off[0]), 64'd29);
    chk("busy start err", 64'(r_err[0]), 64'd1);
    chk("busy start sum", r_res[0], 64'(dot(25, 100, 200)));
    wait_idle();

    // Abort at idx 10.
    run_job(25, 7, 9, 11, 2, 60);
    chk("abort no done", 64'(r_off[0]), 64'hFFFF_FFFF_FFFF_FFFF);
    chk("abort rv", 64'({rv[0], rv[1]}), 64'd0);
    chk("abort busy", 64'({busy[0], busy[1]}), 64'd0);

    // Abort and start together while idle.
    len = 11'd5; start = 1'b1; abort = 1'b1;
    step();
    start = 1'b0; abort = 1'b0;
    @(negedge ACLK);
    chk("abort+start idle", 64'({busy[0], busy[1]}), 64'd0);
    step();

    // Reset mid-job, then a clean job.
    len = 11'd25; xb = '0; wb = '0; start = 1'b1;
    step();
    start = 1'b0;
    repeat (5) step();
    ARESETn = 1'b0;
    @(negedge ACLK);
    chk("midreset en", 64'({x_en[0], x_en[1]}), 64'd0);
    chk("midreset result", result[1], 64'd0);
    step();
    ARESETn = 1'b1;
    step();
    run_job(25, 40, 300, 0, 0, 100);
    chk("post reset done lat3", 64'(r_off[1]), 64'd31);
    chk("post reset sum lat3", r_res[1], 64'(dot(25, 40, 300)));
    wait_idle();

    // Full-depth job.
    run_job(1024, 3, 1000, 0, 0, 1100);
    chk("full len sum", r_res[0], 64'(dot(1024, 3, 1000)));
    wait_idle();

    // Randomized jobs with occasional mid-job start/abort.
    for (int j = 0; j < 30; j++) begin
      int unsigned l, r, kind;
      fill_random();
      step();
      l    = ($urandom_range(0, 9) == 0) ? $urandom_range(0, 1024) : $urandom_range(0, 40);
      r    = $urandom_range(0, 9);
      kind = (r < 2) ? 1 : (r == 2) ? 2 : (r == 3) ? 3 : 0;
      run_job(l, $urandom_range(0, 1023), $urandom_range(0, 1023),
              int'($urandom_range(1, l + 6)), int'(kind), int'(l) + 12);
      wait_idle();
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not finish, %0d failures so far", n_fail);
    $fatal(1, "watchdog expired");
  end

endmodule
